// File: rtl/ram_bist.sv
// March-style BIST initiator for a small single-clock RAM: writes a seed-derived
// pattern to every address, reads it back and compares, then repeats inverted.
module ram_bist #(
  parameter int unsigned            ADDR_WIDTH = 4,
  parameter int unsigned            DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]  SEED       = 8'hA5,
  parameter int unsigned            TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic                  write,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] WriteAddr,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic [ADDR_WIDTH-1:0] ReadAddr,
  input  logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  WriteReady,
  input  logic                  ReadReady
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrAck, StRdReq, StRdAck, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [ADDR_WIDTH+1:0] err_q, err_d;

  logic [DATA_WIDTH-1:0] pat;
  logic                  last_addr;
  logic                  timed_out;

  // Expected data for the current address and pass.
  always_comb begin
    pat = SEED ^ DATA_WIDTH'(addr_q);
    if (phase_q) pat = ~pat;
  end

  assign last_addr = (addr_q == '1);
  assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

  // State register and all datapath registers; reset abandons any RAM transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      wdata_q     <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_addr_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      read_q      <= read_d;
      wdata_q     <= wdata_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_addr_q <= fail_addr_d;
      err_q       <= err_d;
    end
  end

  // Next-state, handshake sequencing, compare and timeout abort.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    write_d     = write_q;
    read_d      = read_q;
    wdata_d     = wdata_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_addr_d = fail_addr_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StWrReq;
          addr_d      = '0;
          phase_d     = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_addr_d = '0;
          err_d       = '0;
        end
      end
      StWrReq: begin
        if (WriteReady) begin
          write_d = 1'b1;
          wdata_d = pat;
          state_d = StWrAck;
        end else if (timed_out) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      StWrAck: begin
        // RAM acknowledges by dropping WriteReady.
        if (!WriteReady) begin
          write_d = 1'b0;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = last_addr ? StRdReq : StWrReq;
        end else if (timed_out) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          write_d   = 1'b0;
        end
      end
      StRdReq: begin
        read_d  = 1'b1;
        state_d = StRdAck;
      end
      StRdAck: begin
        if (ReadReady) begin
          read_d = 1'b0;
          if (ReadData != pat) begin
            if (err_q != '1) err_d = err_q + (ADDR_WIDTH + 2)'(1);
            if (err_q == '0) fail_addr_d = addr_q;
          end
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (!last_addr) begin
            state_d = StRdReq;
          end else if (!phase_q) begin
            phase_d = 1'b1;
            state_d = StWrReq;
          end else begin
            state_d = StDone;
            pass_d  = (err_d == '0);
          end
        end else if (timed_out) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          read_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-state wait counter; restarts on every state change.
  always_comb begin
    if (state_d != state_q || state_q == StIdle || state_q == StDone) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign busy      = (state_q == StWrReq) || (state_q == StWrAck) ||
                     (state_q == StRdReq) || (state_q == StRdAck);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign fail_addr = fail_addr_q;
  assign err_count = err_q;
  assign write     = write_q;
  assign read      = read_q;
  assign WriteAddr = addr_q;
  assign ReadAddr  = addr_q;
  assign WriteData = wdata_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a reactive RAM model and a write/read scoreboard.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, pass, timeout;
  logic [3:0] fail_addr;
  logic [5:0] err_count;
  logic       write, read;
  logic [3:0] WriteAddr, ReadAddr;
  logic [7:0] WriteData, ReadData;
  logic       WriteReady, ReadReady;

  ram_bist #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8),
    .SEED       (8'hA5),
    .TIMEOUT    (255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .fail_addr  (fail_addr),
    .err_count  (err_count),
    .write      (write),
    .read       (read),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .ReadAddr   (ReadAddr),
    .ReadData   (ReadData),
    .WriteReady (WriteReady),
    .ReadReady  (ReadReady)
  );

  always #5 clk = ~clk;

  int cmp_n = 0;
  int err_n = 0;

  // Scoreboard: expected {addr, data} per write and expected addr per read.
  logic [11:0] wq[$];
  logic [3:0]  rq[$];
  logic [7:0]  w3_log[$];
  logic [7:0]  mem [16];

  // RAM model knobs and state.
  int   lat_max = 1;
  bit   hold_wr = 1'b0;
  bit   stuck   = 1'b0;
  int   wr_cnt, rd_cnt;
  int   wcnt, wrise, rcnt;
  bit   w_taken, r_taken;
  logic [3:0] w_addr, r_addr;
  logic [7:0] w_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reactive RAM model, evaluated on the falling edge away from DUT sampling.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst_n) begin
      WriteReady = !hold_wr;
      ReadReady  = 1'b0;
      ReadData   = 8'h00;
      w_taken    = 1'b0;
      r_taken    = 1'b0;
      wcnt = 0; wrise = 0; rcnt = 0;
    end else begin
      check("no_overlap", 32'(write && read), 32'd0);
      if (write) begin
        if (!w_taken) begin
          w_taken = 1'b1;
          wr_cnt++;
          w_addr = WriteAddr;
          w_data = WriteData;
          mem[WriteAddr] = WriteData;
          if (WriteAddr == 4'd3) w3_log.push_back(WriteData);
          if (wq.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
          end else begin
            e = wq.pop_front();
            check("wr_addr", 32'(WriteAddr), 32'(e[11:8]));
            check("wr_data", 32'(WriteData), 32'(e[7:0]));
          end
        end else begin
          check("wr_addr_stable", 32'(WriteAddr), 32'(w_addr));
          check("wr_data_stable", 32'(WriteData), 32'(w_data));
        end
        if (WriteReady) begin
          if (wcnt == 0) begin
            WriteReady = 1'b0;
            wrise = $urandom_range(lat_max - 1, 0);
          end else begin
            wcnt--;
          end
        end
      end else begin
        w_taken = 1'b0;
        if (hold_wr) begin
          WriteReady = 1'b0;
        end else if (!WriteReady) begin
          if (wrise == 0) begin
            WriteReady = 1'b1;
            wcnt = $urandom_range(lat_max - 1, 0);
          end else begin
            wrise--;
          end
        end
      end
      if (read) begin
        if (!r_taken) begin
          r_taken = 1'b1;
          rd_cnt++;
          r_addr = ReadAddr;
          if (rq.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
          else check("rd_addr", 32'(ReadAddr), 32'(rq.pop_front()));
        end else begin
          check("rd_addr_stable", 32'(ReadAddr), 32'(r_addr));
        end
        if (!ReadReady) begin
          if (rcnt == 0) begin
            ReadReady = 1'b1;
            ReadData  = mem[ReadAddr];
            if (stuck && ReadAddr == 4'd5) ReadData[0] = 1'b0;
          end else begin
            rcnt--;
          end
        end
      end else begin
        r_taken   = 1'b0;
        ReadReady = 1'b0;
        rcnt = $urandom_range(lat_max - 1, 0);
      end
    end
  end

  task automatic check_idle_outs(input string tag);
    check({tag, "_write"},     32'(write),     32'd0);
    check({tag, "_read"},      32'(read),      32'd0);
    check({tag, "_waddr"},     32'(WriteAddr), 32'd0);
    check({tag, "_raddr"},     32'(ReadAddr),  32'd0);
    check({tag, "_wdata"},     32'(WriteData), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_pass"},      32'(pass),      32'd0);
    check({tag, "_timeout"},   32'(timeout),   32'd0);
    check({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  // Loads the scoreboard for one full run, then pulses start for one cycle.
  task automatic launch(input bit expect_io);
    logic [7:0] d;
    wq.delete(); rq.delete(); w3_log.delete();
    wr_cnt = 0; rd_cnt = 0;
    if (expect_io) begin
      for (int p = 0; p < 2; p++) begin
        for (int a = 0; a < 16; a++) begin
          d = 8'hA5 ^ {4'h0, 4'(a)};
          if (p == 1) d = ~d;
          wq.push_back({4'(a), d});
        end
        for (int a = 0; a < 16; a++) rq.push_back(4'(a));
      end
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check("done_in_time", 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag, input bit exp_pass, input logic [3:0] exp_fa,
                              input logic [5:0] exp_err, input bit exp_to);
    check({tag, "_done"},      32'(done),      32'd1);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_pass"},      32'(pass),      32'(exp_pass));
    check({tag, "_timeout"},   32'(timeout),   32'(exp_to));
    check({tag, "_fail_addr"}, 32'(fail_addr), 32'(exp_fa));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    int cyc;
    logic [7:0] w3a, w3b;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal RAM, with a stray start mid-run that must be ignored.
    launch(1'b1);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_write_not_yet", 32'(write), 32'd0);
    @(negedge clk);
    check("t1_write_first", 32'(write), 32'd1);
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("t1_busy_ignore_start", 32'(busy), 32'd1);
    wait_done(2000, cyc);
    check_result("t1", 1'b1, 4'd0, 6'd0, 1'b0);
    check("t1_wq_empty", 32'(wq.size()), 32'd0);
    check("t1_rq_empty", 32'(rq.size()), 32'd0);
    check("t1_addr3_writes", 32'(w3_log.size()), 32'd2);
    if (w3_log.size() == 2) begin
      w3a = w3_log[0];
      w3b = w3_log[1];
      check("t1_addr3_pass0", 32'(w3a), 32'h0A6);
      check("t1_addr3_pass1", 32'(w3b), 32'h059);
    end

    // Stuck-at-0 on bit 0 of address 5: only the inverted pass miscompares.
    stuck = 1'b1;
    launch(1'b1);
    wait_done(2000, cyc);
    check_result("t2", 1'b0, 4'd5, 6'd1, 1'b0);

    // Start while done clears results and reruns against a healthy RAM.
    stuck = 1'b0;
    launch(1'b1);
    check("t2r_done_cleared", 32'(done), 32'd0);
    check("t2r_busy", 32'(busy), 32'd1);
    check("t2r_err_cleared", 32'(err_count), 32'd0);
    check("t2r_fa_cleared", 32'(fail_addr), 32'd0);
    wait_done(2000, cyc);
    check_result("t2r", 1'b1, 4'd0, 6'd0, 1'b0);

    // WriteReady never rises: abort on handshake timeout.
    hold_wr = 1'b1;
    @(negedge clk);
    launch(1'b0);
    wait_done(400, cyc);
    check_result("t3", 1'b0, 4'd0, 6'd0, 1'b1);
    check("t3_latency_window", 32'(cyc >= 255 && cyc <= 257), 32'd1);
    check("t3_no_write", 32'(wr_cnt), 32'd0);
    hold_wr = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset during the read phase of the inverted pass.
    launch(1'b1);
    cyc = 0;
    while (!(wr_cnt == 32 && rd_cnt >= 21 && read) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_reached_read_p1", 32'(read), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle_outs("t4_async_reset");
    @(negedge clk) rst_n = 1'b1;
    wq.delete(); rq.delete();
    @(negedge clk);
    launch(1'b1);
    wait_done(2000, cyc);
    check_result("t4", 1'b1, 4'd0, 6'd0, 1'b0);

    // Random 1-10 cycle handshake latency.
    lat_max = 10;
    launch(1'b1);
    wait_done(5000, cyc);
    check_result("t5", 1'b1, 4'd0, 6'd0, 1'b0);
    check("t5_wq_empty", 32'(wq.size()), 32'd0);
    check("t5_rq_empty", 32'(rq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test initiator for the 16-entry single-clock RAM. It drives the RAM's write/read handshake ports as the master: it fills every address with a known pattern, reads every address back and compares, then repeats with the inverted pattern. It sits beside the RAM, between the RAM and the control logic that launches the test, and reports pass/fail, the first failing address and an error count.

## Interface
- ADDR_WIDTH, 4, RAM address width; test covers 2^ADDR_WIDTH addresses
- DATA_WIDTH, 8, RAM data width
- SEED, 8'hA5, pattern seed (DATA_WIDTH bits)
- TIMEOUT, 255, max cycles to wait on any single handshake
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, launches a test run
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  high from end of run until next accepted start
- pass  out  1  valid while done: 1 = zero errors and no timeout
- timeout  out  1  valid while done: run aborted on a handshake timeout
- fail_addr  out  ADDR_WIDTH  first miscomparing address (0 if none)
- err_count  out  ADDR_WIDTH+2  miscompare count, saturates at all-ones
- write  out  1  write request to RAM
- read  out  1  read request to RAM
- WriteAddr  out  ADDR_WIDTH  write address
- WriteData  out  DATA_WIDTH  write data
- ReadAddr  out  ADDR_WIDTH  read address
- ReadData  in  DATA_WIDTH  RAM read data, valid while ReadReady=1
- WriteReady  in  1  RAM can accept a write
- ReadReady  in  1  RAM read data valid

## Operation
- Pattern: P(a,p) = SEED ^ zero-extended a; pass p=1 uses ~P(a,0). Pass 0 then pass 1.
- Per pass: write phase addr 0..max, then read phase addr 0..max, compare each ReadData to P(a,p).
- States: IDLE -> WR_REQ -> WR_ACK -> (next addr) ... -> RD_REQ -> RD_ACK -> (next addr) ... -> next pass or DONE.
- IDLE: start=1 -> WR_REQ, addr=0, pass=0, clears pass/timeout/fail_addr/err_count, busy=1.
- WR_REQ: wait WriteReady=1; then drive write=1, WriteAddr, WriteData -> WR_ACK.
- WR_ACK: hold write/addr/data stable until WriteReady sampled 0; then write=0, advance addr; after last addr -> RD_REQ with addr=0.
- RD_REQ: drive read=1, ReadAddr -> RD_ACK.
- RD_ACK: hold read/ReadAddr until ReadReady sampled 1; compare ReadData in that same cycle; read=0 next edge; advance addr; after last addr -> next pass (WR_REQ, pass=1) or DONE.
- Miscompare: err_count+1 (saturating); fail_addr captured only on first error of the run.
- Timeout: a cycle counter resets on every state change; reaching TIMEOUT in WR_REQ, WR_ACK or RD_ACK -> DONE with timeout=1, pass=0, write=read=0.
- DONE: done=1, busy=0, pass = (err_count==0 && !timeout); start=1 -> restart as from IDLE.
- start while busy: ignored.
- Address counter wraps at 2^ADDR_WIDTH-1; wrap ends the phase, never re-tests addr 0.

## Timing
- Reset values: write=0, read=0, WriteAddr=0, ReadAddr=0, WriteData=0, busy=0, done=0, pass=0, timeout=0, fail_addr=0, err_count=0; state IDLE.
- reset asserted mid-run: all outputs to reset values immediately (asynchronously); the RAM transaction is abandoned.
- start sampled at edge N -> busy=1 at edge N+1; write may first rise at edge N+2 if WriteReady=1.
- write and read are never high in the same cycle; at most one outstanding request.
- Minimum write: 3 cycles (REQ, ACK with WriteReady drop, release); minimum read: 3 cycles.
- done rises the edge after the final compare; busy falls on the same edge.

## Test plan
- Ideal RAM model (WriteReady drops 1 cycle after write, ReadReady 1 cycle after read) -> done=1, pass=1, err_count=0, timeout=0; addr 3 written with 8'hA6 in pass 0 and 8'h59 in pass 1.
- RAM model with bit 0 of addr 5 stuck at 0 -> pass 0 clean (8'hA0), pass 1 fails (8'h5F); done=1, pass=0, fail_addr=5, err_count=1.
- WriteReady held 0 after start -> after TIMEOUT=255 cycles in WR_REQ, done=1, timeout=1, pass=0, write never asserted.
- reset pulled low during the read phase of pass 1 -> all outputs 0 within the same cycle, state IDLE; new start then completes a full passing run.
- start pulsed again while busy -> ignored, run results unchanged; start pulsed while done -> results cleared, new run begins.
- RAM model with randomized 1-10 cycle handshake latency -> pass=1; write/read never overlap; addr/data stable while each request is held.
